// File: rtl/seg_pkg.sv
// Shared types and constants for the multiplexed 7-segment scan controller.
package seg_pkg;

  typedef enum logic {ON, GAP} scan_state_e;

  localparam logic [7:0] COM_OFF   = 8'hFF;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  // Segment patterns a..g (a = bit 6) for BCD digits 9 down to 0.
  localparam logic [9:0][6:0] SEG_TAB = {
    7'b1111011, 7'b1111111, 7'b1110000, 7'b1011111, 7'b1011011,
    7'b0110011, 7'b1111001, 7'b1101101, 7'b0110000, 7'b1111110
  };

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Producer-to-display frame load handshake.
interface seg_scan_ctrl_if;
  logic        LD_REQ;
  logic [31:0] LD_DATA;
  logic        LD_ACK;

  modport master (output LD_REQ, output LD_DATA, input LD_ACK);
  modport slave  (input LD_REQ, input LD_DATA, output LD_ACK);
endinterface

// File: rtl/seg_dec4to7.sv
// Combinational BCD to 7-segment decoder; non-BCD codes render as a blank digit.
module seg_dec4to7
  import seg_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    if (bcd_i <= 4'd9) seg_o = SEG_TAB[bcd_i];
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Scan scheduler for an 8-digit multiplexed display: per-digit ON window, blanking
// gap, atomic frame commit at the digit 7 -> 0 boundary and leading-zero blanking.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int DIV       = 1000,
  parameter int ON_TICKS  = 3,
  parameter int GAP_TICKS = 1
) (
  input  logic                  C,
  input  logic                  R,
  input  logic                  EN,
  input  logic                  LZB,
  seg_scan_ctrl_if.slave        ld,
  output logic [2:0]            SEL,
  output logic [7:0]            SEG_COM,
  output logic [6:0]            SEG7,
  output logic                  FRAME
);

  localparam int PW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int TMAX = (ON_TICKS > GAP_TICKS) ? ON_TICKS : GAP_TICKS;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);
  localparam logic [TW-1:0] ON_LAST  = TW'(ON_TICKS - 1);
  localparam logic [TW-1:0] GAP_LAST = TW'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);

  logic [PW-1:0] presc_q, presc_d;
  logic [TW-1:0] tick_q, tick_d;
  scan_state_e   state_q, state_d;
  logic [2:0]    sel_q, sel_d;
  logic [31:0]   active_q, active_d;
  logic [7:0]    com_q, com_d;
  logic [6:0]    seg7_q, seg7_d;
  logic          ack_q, ack_d;
  logic          frame_q, frame_d;

  logic          scan_tick;
  logic          gap_exit;
  logic          lz_blank;
  logic [3:0]    dig_nib;
  logic [6:0]    dec_seg;

  assign dig_nib  = active_q[{sel_q, 2'b00} +: 4];
  // A digit is a leading zero when it and every digit above it are zero.
  assign lz_blank = LZB && (sel_q != 3'd0) && ((active_q >> {sel_q, 2'b00}) == 32'd0);

  seg_dec4to7 u_dec (
    .bcd_i (dig_nib),
    .seg_o (dec_seg)
  );

  always_comb begin
    presc_d   = presc_q;
    tick_d    = tick_q;
    state_d   = state_q;
    sel_d     = sel_q;
    active_d  = active_q;
    ack_d     = 1'b0;
    frame_d   = 1'b0;
    gap_exit  = 1'b0;
    scan_tick = EN && (presc_q == PRE_LAST);

    if (EN) presc_d = scan_tick ? '0 : presc_q + PW'(1);

    if (scan_tick) begin
      unique case (state_q)
        ON: begin
          if (tick_q == ON_LAST) begin
            tick_d = '0;
            if (GAP_TICKS == 0) gap_exit = 1'b1;
            else                state_d  = GAP;
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
        GAP: begin
          if (tick_q == GAP_LAST) begin
            tick_d   = '0;
            state_d  = ON;
            gap_exit = 1'b1;
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
        default: ;
      endcase
    end

    // The only point where a new frame may be adopted; ack_q guards a held REQ.
    if (gap_exit) begin
      sel_d = sel_q + 3'd1;
      if (sel_q == 3'd7) begin
        frame_d = 1'b1;
        if (ld.LD_REQ && !ack_q) begin
          active_d = ld.LD_DATA;
          ack_d    = 1'b1;
        end
      end
    end

    com_d  = COM_OFF;
    seg7_d = SEG_BLANK;
    if (EN && (state_q == ON)) begin
      com_d  = ~(8'b1 << sel_q);
      seg7_d = lz_blank ? SEG_BLANK : dec_seg;
    end
  end

  always_ff @(posedge C or negedge R) begin
    if (!R) begin
      presc_q  <= '0;
      tick_q   <= '0;
      state_q  <= ON;
      sel_q    <= 3'd0;
      active_q <= 32'd0;
      com_q    <= COM_OFF;
      seg7_q   <= SEG_BLANK;
      ack_q    <= 1'b0;
      frame_q  <= 1'b0;
    end else begin
      presc_q  <= presc_d;
      tick_q   <= tick_d;
      state_q  <= state_d;
      sel_q    <= sel_d;
      active_q <= active_d;
      com_q    <= com_d;
      seg7_q   <= seg7_d;
      ack_q    <= ack_d;
      frame_q  <= frame_d;
    end
  end

  assign SEL       = sel_q;
  assign SEG_COM   = com_q;
  assign SEG7      = seg7_q;
  assign FRAME     = frame_q;
  assign ld.LD_ACK = ack_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl: a decode/LZB vector table plus hand-written
// sequences for scan timing, handshake, enable freeze, reset and gapless scanning.
module tb_seg_scan_ctrl;

  logic       C = 1'b0;
  logic       R = 1'b0;
  logic       EN = 1'b1;
  logic       LZB = 1'b0;
  logic [2:0] SEL, SEL2;
  logic [7:0] SEG_COM, SEG_COM2;
  logic [6:0] SEG7, SEG72;
  logic       FRAME, FRAME2;

  int checks = 0;
  int errors = 0;
  int ack_cnt = 0;

  seg_scan_ctrl_if ifc ();
  seg_scan_ctrl_if ifc2 ();

  seg_scan_ctrl #(.DIV(4), .ON_TICKS(3), .GAP_TICKS(1)) dut (
    .C(C), .R(R), .EN(EN), .LZB(LZB), .ld(ifc),
    .SEL(SEL), .SEG_COM(SEG_COM), .SEG7(SEG7), .FRAME(FRAME)
  );

  seg_scan_ctrl #(.DIV(4), .ON_TICKS(3), .GAP_TICKS(0)) dut2 (
    .C(C), .R(R), .EN(1'b1), .LZB(1'b0), .ld(ifc2),
    .SEL(SEL2), .SEG_COM(SEG_COM2), .SEG7(SEG72), .FRAME(FRAME2)
  );

  always #5 C = ~C;

  always @(negedge C) if (ifc.LD_ACK === 1'b1) ack_cnt++;

  typedef struct {
    logic [31:0] data;
    logic        lzb;
    logic [7:0]  com;
    logic [6:0]  seg;
  } vec_t;

  vec_t vecs [20];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic wait_com(input logic [7:0] v, input string name);
    int n = 0;
    do begin @(negedge C); n++; end while (SEG_COM !== v && n < 400);
    if (SEG_COM !== v) check({name, "_timeout"}, {24'd0, SEG_COM}, {24'd0, v});
  endtask

  task automatic wait_sel(input logic [2:0] v);
    int n = 0;
    do begin @(negedge C); n++; end while (SEL !== v && n < 400);
    if (SEL !== v) check("wait_sel_timeout", {29'd0, SEL}, {29'd0, v});
  endtask

  task automatic load(input logic [31:0] d);
    int n = 0;
    ifc.LD_DATA = d;
    ifc.LD_REQ  = 1'b1;
    do begin @(negedge C); n++; end while (ifc.LD_ACK !== 1'b1 && n < 400);
    check("load_ack", {31'd0, ifc.LD_ACK}, 32'd1);
    ifc.LD_REQ = 1'b0;
  endtask

  task automatic measure(input logic [7:0] v, output int n);
    n = 0;
    while (SEG_COM === v && n < 1000) begin n++; @(negedge C); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, acks, a0, ffs;
    logic seen4;
    logic [31:0] cur;
    logic [7:0] m;

    vecs[0]  = '{32'h87654321, 1'b0, 8'hFE, 7'b0110000};
    vecs[1]  = '{32'h87654321, 1'b0, 8'hFD, 7'b1101101};
    vecs[2]  = '{32'h87654321, 1'b0, 8'hFB, 7'b1111001};
    vecs[3]  = '{32'h87654321, 1'b0, 8'hF7, 7'b0110011};
    vecs[4]  = '{32'h87654321, 1'b0, 8'hEF, 7'b1011011};
    vecs[5]  = '{32'h87654321, 1'b0, 8'hDF, 7'b1011111};
    vecs[6]  = '{32'h87654321, 1'b0, 8'hBF, 7'b1110000};
    vecs[7]  = '{32'h87654321, 1'b0, 8'h7F, 7'b1111111};
    vecs[8]  = '{32'h00000105, 1'b1, 8'h7F, 7'b0000000};
    vecs[9]  = '{32'h00000105, 1'b1, 8'hF7, 7'b0000000};
    vecs[10] = '{32'h00000105, 1'b1, 8'hFB, 7'b0110000};
    vecs[11] = '{32'h00000105, 1'b1, 8'hFD, 7'b1111110};
    vecs[12] = '{32'h00000105, 1'b1, 8'hFE, 7'b1011011};
    vecs[13] = '{32'h00000105, 1'b0, 8'h7F, 7'b1111110};
    vecs[14] = '{32'h00000000, 1'b1, 8'hFE, 7'b1111110};
    vecs[15] = '{32'h00000000, 1'b1, 8'hFD, 7'b0000000};
    vecs[16] = '{32'h00A00000, 1'b0, 8'hDF, 7'b0000000};
    vecs[17] = '{32'h00A00000, 1'b0, 8'hBF, 7'b1111110};
    vecs[18] = '{32'h90000000, 1'b1, 8'h7F, 7'b1111011};
    vecs[19] = '{32'h90000000, 1'b1, 8'hBF, 7'b1111110};

    ifc.LD_REQ = 1'b0;  ifc.LD_DATA = 32'd0;
    ifc2.LD_REQ = 1'b0; ifc2.LD_DATA = 32'd0;

    // Reset state
    repeat (3) @(negedge C);
    check("rst_com", {24'd0, SEG_COM}, 32'hFF);
    check("rst_seg7", {25'd0, SEG7}, 32'd0);
    check("rst_sel", {29'd0, SEL}, 32'd0);
    check("rst_ack", {31'd0, ifc.LD_ACK}, 32'd0);
    check("rst_frame", {31'd0, FRAME}, 32'd0);
    check("rst2_com", {24'd0, SEG_COM2}, 32'hFF);
    check("rst2_sel_seg", {22'd0, SEL2, SEG72}, 32'd0);
    R = 1'b1;

    // Scan timing from reset
    wait_com(8'hFE, "first_fe");
    measure(8'hFE, n); check("run_fe", n, 12);
    measure(8'hFF, n); check("run_gap", n, 4);
    measure(8'hFD, n); check("run_fd", n, 12);
    n = 0;
    do begin @(negedge C); n++; end while (FRAME !== 1'b1 && n < 300);
    check("frame_seen", {31'd0, FRAME}, 32'd1);
    n = 0;
    do begin @(negedge C); n++; end while (FRAME !== 1'b1 && n < 300);
    check("frame_period", n, 128);

    // Vector table: decode, LZB and invalid nibbles
    cur = 32'hFFFFFFFF;
    for (int i = 0; i < 20; i++) begin
      if (vecs[i].data != cur) begin
        load(vecs[i].data);
        cur = vecs[i].data;
      end
      LZB = vecs[i].lzb;
      wait_com(vecs[i].com, "vec_com");
      check($sformatf("vec%0d_seg7", i), {25'd0, SEG7}, {25'd0, vecs[i].seg});
    end
    LZB = 1'b0;

    // Handshake raised mid-frame
    load(32'h87654321);
    wait_sel(3'd3);
    ifc.LD_DATA = 32'h11111111;
    ifc.LD_REQ  = 1'b1;
    seen4 = 1'b0; acks = 0; n = 0;
    while (n < 300 && acks == 0) begin
      @(negedge C); n++;
      if (SEG_COM === 8'hEF && !seen4) begin
        seen4 = 1'b1;
        check("hs_old_digit4", {25'd0, SEG7}, {25'd0, 7'b1011011});
      end
      if (ifc.LD_ACK === 1'b1) acks++;
    end
    check("hs_ack", acks, 1);
    check("hs_ack_sel", {29'd0, SEL}, 32'd0);
    check("hs_ack_after_d4", {31'd0, seen4}, 32'd1);
    repeat (2) begin
      @(negedge C);
      if (ifc.LD_ACK === 1'b1) acks++;
    end
    check("hs_single_ack", acks, 1);
    ifc.LD_REQ = 1'b0;
    wait_com(8'hFE, "hs_d0");
    check("hs_new_digit0", {25'd0, SEG7}, {25'd0, 7'b0110000});
    wait_com(8'h7F, "hs_d7");
    check("hs_new_digit7", {25'd0, SEG7}, {25'd0, 7'b0110000});

    // EN dropped mid-ON of digit 2
    wait_com(8'hFB, "en_d2");
    repeat (4) @(negedge C);
    EN = 1'b0;
    @(negedge C);
    check("en_off_com", {24'd0, SEG_COM}, 32'hFF);
    check("en_off_sel", {29'd0, SEL}, 32'd2);
    repeat (9) @(negedge C);
    check("en_hold_sel", {29'd0, SEL}, 32'd2);
    check("en_hold_com", {24'd0, SEG_COM}, 32'hFF);
    EN = 1'b1;
    @(negedge C);
    measure(8'hFB, n);
    check("en_remaining", n, 7);
    check("en_then_gap", {24'd0, SEG_COM}, 32'hFF);

    // Reset mid-frame with a pending request
    wait_sel(3'd1);
    ifc.LD_DATA = 32'h22222222;
    ifc.LD_REQ  = 1'b1;
    wait_sel(3'd5);
    R = 1'b0;
    #1;
    check("arst_com", {24'd0, SEG_COM}, 32'hFF);
    check("arst_seg7", {25'd0, SEG7}, 32'd0);
    check("arst_sel", {29'd0, SEL}, 32'd0);
    check("arst_ack", {31'd0, ifc.LD_ACK}, 32'd0);
    @(negedge C);
    ifc.LD_REQ = 1'b0;
    repeat (2) @(negedge C);
    R = 1'b1;
    a0 = ack_cnt;
    for (int d = 0; d < 8; d++) begin
      m = 8'b1 << d;
      wait_com(~m, "arst_dig");
      check($sformatf("arst_digit%0d", d), {25'd0, SEG7}, {25'd0, 7'b1111110});
    end
    check("arst_no_ack", ack_cnt - a0, 0);

    // Gapless instance: commons never all-off between digits
    ffs = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge C);
      if (SEG_COM2 === 8'hFF) ffs++;
    end
    check("gap0_no_off", ffs, 0);
    n = 0;
    do begin @(negedge C); n++; end while (SEG_COM2 !== 8'h7F && n < 300);
    n = 0;
    do begin @(negedge C); n++; end while (SEG_COM2 !== 8'hFE && n < 300);
    n = 0;
    while (SEG_COM2 === 8'hFE && n < 300) begin n++; @(negedge C); end
    check("gap0_run_fe", n, 12);
    check("gap0_next_fd", {24'd0, SEG_COM2}, 32'hFD);
    n = 0;
    do begin @(negedge C); n++; end while (FRAME2 !== 1'b1 && n < 300);
    n = 0;
    do begin @(negedge C); n++; end while (FRAME2 !== 1'b1 && n < 300);
    check("gap0_frame_period", n, 96);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
Scan scheduler for the 8-digit multiplexed 7-segment display. It time-shares the single segment bus across the eight common lines. Each digit gets a programmable on-time, followed by an all-off blanking gap that prevents ghosting. New 8-digit BCD frames are committed atomically at frame boundaries through a req/ack handshake. Optional leading-zero blanking is supported. It sits between the counting/data logic (the producer) and the display pins.

Parameters:
DIV, 1000, clock cycles per scan tick (>=1)
ON_TICKS, 3, ticks a digit is driven (>=1)
GAP_TICKS, 1, ticks with all commons off after each digit (0 = no gap)

Ports:
C  input  1  clock, rising edge
R  input  1  reset, asynchronous, active-low
EN  input  1  scan enable; 0 freezes scanning and blanks the display
LZB  input  1  leading-zero blanking enable
LD_REQ  input  1  producer requests commit of LD_DATA; held high until LD_ACK
LD_DATA  input  32  8 BCD nibbles; [3:0] = digit 0 (rightmost), [31:28] = digit 7
LD_ACK  output  1  one-cycle pulse: LD_DATA committed to the active frame
SEL  output  3  index of the digit currently scheduled
SEG_COM  output  8  common lines, active-low, one-hot-zero; bit n = digit n
SEG7  output  7  segments a..g, a = bit 6, active-high (0 -> 1111110, 1 -> 0110000)
FRAME  output  1  one-cycle pulse when digit 0 begins its ON phase

Behaviour:
- Clocking and reset: single clock C. R low asynchronously resets:
  - SEL = 0, SEG_COM = 8'hFF, SEG7 = 0, LD_ACK = 0, FRAME = 0.
  - active frame = 0, prescaler = 0, tick count = 0, state = ON.
  - A pending LD_REQ is dropped; it is never acknowledged for pre-reset data.
- Prescaler: counts 0..DIV-1 while EN = 1. A tick is the cycle in which it equals DIV-1; it then wraps to 0.
- FSM states ON and GAP; the tick counter counts ticks within a state.
  - ON: after ON_TICKS ticks, go to GAP. If GAP_TICKS = 0, skip GAP and perform the GAP exit action directly.
  - GAP: after GAP_TICKS ticks, SEL <= SEL+1 (mod 8) and the state returns to ON.
  - Frame boundary: GAP exit with SEL = 7. On that same cycle:
    - If LD_REQ = 1 and LD_ACK = 0, active <= LD_DATA and LD_ACK = 1 for one cycle.
    - FRAME pulses on the same cycle.
  - LD_REQ is never sampled outside the frame boundary. Data displayed mid-frame never changes.
- Outputs are registered and reflect state/SEL/active with one cycle of latency.
  - ON: SEG_COM = ~(1 << SEL); SEG7 = decode(active nibble SEL).
  - GAP: SEG_COM = 8'hFF, SEG7 = 0.
- Decode: nibble values 0-9 use the standard table; values 10-15 give SEG7 = 0 (blank digit, common still driven).
- LZB = 1: digit n (n >= 1) is blanked (SEG7 = 0) when nibble n and all higher nibbles are 0. Digit 0 is never blanked.
- EN = 0:
  - Prescaler, tick counter, state and SEL hold.
  - Next cycle SEG_COM = 8'hFF and SEG7 = 0.
  - No ACK or FRAME is issued.
  - When EN returns to 1, scanning resumes at the held position with the remaining ticks.
- Simultaneous events:
  - R low overrides everything.
  - A frame boundary with EN = 0 cannot occur.
  - LD_REQ raised on the boundary cycle itself is accepted.
- Timing example (DIV = 4, ON_TICKS = 3, GAP_TICKS = 1): digit period 16 clocks, frame period 128 clocks.

Decomposition:
- Shared package seg_pkg:
  - state enum {ON, GAP}
  - COM_OFF = 8'hFF, SEG_BLANK = 7'b0000000
  - BCD-to-segment table constants
- Sub-module seg_dec4to7: combinational 4-to-7 decoder, with invalid inputs producing blank.

Test Plan:
- Reset then scan, with DIV = 4, ON = 3, GAP = 1, EN = 1 and frame 0x87654321 committed:
  - SEG_COM = FE for 12 clocks, then FF for 4, then FD for 12, and so on.
  - SEG7 in the FE window = 0110000; FRAME pulses every 128 clocks.
- Handshake: LD_REQ raised while SEL = 3 with 0x11111111:
  - No ACK until the SEL 7 -> 0 boundary; then exactly one LD_ACK pulse.
  - Digit 4 still shows the old value; digit 0 of the next frame shows 0110000.
  - REQ held 2 cycles after ACK causes no second ACK.
- LZB = 1 with 0x00000105: digits 7..3 SEG7 = 0; digit 2 = 0110000, digit 1 = 1111110, digit 0 = 1011011. With frame 0, only digit 0 shows 1111110.
- Nibble 0xA in digit 5 -> SEG7 = 0 in digit 5's ON window while SEG_COM = DF.
- EN dropped mid-ON of digit 2:
  - SEG_COM = FF next cycle; SEL stays 2.
  - After EN returns, digit 2 is driven for exactly its remaining clocks.
- R pulsed low mid-frame with LD_REQ high:
  - Outputs are immediately FF/0 and SEL = 0; no LD_ACK; the active frame shows all 1111110.
  - With GAP_TICKS = 0, SEG_COM never reads FF between digits.
